// File: rtl/proc_bus_requester.sv
// Processor-side requester for Processor_Bus: queues commands, runs one bus transfer at a time
// and returns ordered responses. Define PBR_TIMEOUT_EN to enable the WAIT-state watchdog.
module proc_bus_requester #(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [1:0] cmd_sel,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [7:0] cmd_wait,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_write,
    output logic       rsp_err,
    output logic       pb_start,
    output logic       pb_write,
    output logic [1:0] pb_sel,
    output logic [7:0] pb_addr,
    output logic [7:0] pb_wdata,
    output logic [7:0] pb_wait_cycles,
    input  logic       pb_ready,
    input  logic [7:0] pb_rdata,
    output logic       busy,
    output logic [1:0] fsm_state
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam logic [CAW:0] CMD_FULL = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0] RSP_FULL = (RAW+1)'(RSP_DEPTH);

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_cmd_depth
        $error("CMD_DEPTH must be a power of 2 and at least 2");
    end
    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_rsp_depth
        $error("RSP_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_next;

    // Valid/ready: a command transfers on any edge where cmd_valid & cmd_ready,
    // a response on any edge where rsp_valid & rsp_ready; both sides may hold valid indefinitely.
    logic [26:0]    cmd_mem [CMD_DEPTH];
    logic [CAW-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [CAW:0]   cmd_count;
    logic           cmd_push, cmd_pop;
    logic [26:0]    cmd_head;

    logic [9:0]     rsp_mem [RSP_DEPTH];
    logic [RAW-1:0] rsp_wr_ptr, rsp_rd_ptr;
    logic [RAW:0]   rsp_count;
    logic           rsp_push, rsp_pop;

    logic       load_en, cap_en, cap_write, cap_err, timed_out;
    logic [7:0] cap_rdata;
    logic [7:0] res_rdata;
    logic       res_write, res_err;

    assign cmd_ready = (cmd_count != CMD_FULL);
    assign cmd_push  = cmd_valid & cmd_ready;
    assign cmd_head  = cmd_mem[cmd_rd_ptr];

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr] <= {cmd_write, cmd_sel, cmd_addr, cmd_wdata, cmd_wait};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count <= cmd_count + 1'b1;
                2'b01:   cmd_count <= cmd_count - 1'b1;
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign {rsp_rdata, rsp_write, rsp_err} = rsp_mem[rsp_rd_ptr];

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_mem[rsp_wr_ptr] <= {res_rdata, res_write, res_err};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count <= rsp_count + 1'b1;
                2'b01:   rsp_count <= rsp_count - 1'b1;
                default: rsp_count <= rsp_count;
            endcase
        end
    end

`ifdef PBR_TIMEOUT_EN
    logic [15:0] wait_timer;

    // Holds at zero outside WAIT, so it is always cleared on entry.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT) begin
            wait_timer <= '0;
        end else begin
            wait_timer <= wait_timer + 1'b1;
        end
    end

    assign timed_out = (state == WAIT) && (wait_timer == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only the IDLE state pops, and only if the result is guaranteed a response slot,
    // so the RESP push can never overflow.
    always_comb begin
        state_next = state;
        cmd_pop    = 1'b0;
        load_en    = 1'b0;
        cap_en     = 1'b0;
        cap_rdata  = 8'h00;
        cap_write  = 1'b0;
        cap_err    = 1'b0;
        rsp_push   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_count != '0 && rsp_count < RSP_FULL) begin
                    cmd_pop = 1'b1;
                    if (cmd_head[25:24] == 2'd0) begin
                        cap_en     = 1'b1;
                        cap_write  = cmd_head[26];
                        cap_err    = 1'b1;
                        state_next = RESP;
                    end else begin
                        load_en    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (pb_ready) begin
                    cap_en     = 1'b1;
                    cap_rdata  = pb_write ? 8'h00 : pb_rdata;
                    cap_write  = pb_write;
                    state_next = RESP;
                end else if (timed_out) begin
                    cap_en     = 1'b1;
                    cap_write  = pb_write;
                    cap_err    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_push   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pb_write       <= 1'b0;
            pb_sel         <= 2'd0;
            pb_addr        <= 8'h00;
            pb_wdata       <= 8'h00;
            pb_wait_cycles <= 8'h00;
            res_rdata      <= 8'h00;
            res_write      <= 1'b0;
            res_err        <= 1'b0;
        end else begin
            if (load_en) begin
                {pb_write, pb_sel, pb_addr, pb_wdata, pb_wait_cycles} <= cmd_head;
            end else if (state == RESP) begin
                pb_sel <= 2'd0;
            end
            if (cap_en) begin
                res_rdata <= cap_rdata;
                res_write <= cap_write;
                res_err   <= cap_err;
            end
        end
    end

    assign pb_start  = (state == ISSUE);
    assign busy      = (state != IDLE) || (cmd_count != '0);
    assign fsm_state = state;

endmodule

// File: tb/tb_proc_bus_requester.sv
// Bench for proc_bus_requester: directed vector table, hand-written corner sequences and
// randomized traffic checked against a command-order response model.
module tb_proc_bus_requester;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [1:0] cmd_sel;
    logic [7:0] cmd_addr, cmd_wdata, cmd_wait;
    logic       rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [7:0] rsp_rdata;
    logic       pb_start, pb_write, pb_ready, busy;
    logic [1:0] pb_sel, fsm_state;
    logic [7:0] pb_addr, pb_wdata, pb_wait_cycles, pb_rdata;

    int checks   = 0;
    int failures = 0;

    logic [9:0]  exp_q[$];
    logic [26:0] bus_q[$];

    logic slave_auto = 1'b0;
    logic slave_rand = 1'b0;
    logic rand_rsp   = 1'b0;
    logic rsp_man    = 1'b0;
    logic rsp_rand   = 1'b0;
    logic prev_start = 1'b0;

    logic [9:0]  mon_e;
    logic [26:0] mon_b;
    logic [26:0] sl_f;
    int          sl_d;
    logic [26:0] bus_fields;

    typedef struct packed {
        logic       w;
        logic [1:0] sel;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] wt;
        logic [7:0] rdata;
        logic       rw;
        logic       err;
    } vec_t;

    vec_t tbl [7];

    assign rsp_ready  = rand_rsp ? rsp_rand : rsp_man;
    assign bus_fields = {pb_write, pb_sel, pb_addr, pb_wdata, pb_wait_cycles};

    proc_bus_requester dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_sel        (cmd_sel),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wait       (cmd_wait),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_write      (rsp_write),
        .rsp_err        (rsp_err),
        .pb_start       (pb_start),
        .pb_write       (pb_write),
        .pb_sel         (pb_sel),
        .pb_addr        (pb_addr),
        .pb_wdata       (pb_wdata),
        .pb_wait_cycles (pb_wait_cycles),
        .pb_ready       (pb_ready),
        .pb_rdata       (pb_rdata),
        .busy           (busy),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    // Read data the bench's slave returns for an address.
    function automatic logic [7:0] slave_data(input logic [7:0] a);
        return a ^ 8'h1C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [1:0] s, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] wt);
        int  n;
        logic ok;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_sel   = s;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wait  = wt;
        n  = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n > 300) begin
                check("cmd_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        cmd_valid = 1'b0;
        if (ok) begin
            if (s == 2'd0) exp_q.push_back({8'h00, w, 1'b1});
            else           exp_q.push_back({(w ? 8'h00 : slave_data(a)), w, 1'b0});
            if (s != 2'd0) bus_q.push_back({w, s, a, d, wt});
        end
    endtask

    task automatic drain(input string name);
        int n;
        rsp_man = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy || rsp_valid) && n < 600) begin
            step();
            n++;
        end
        rsp_man = 1'b0;
        check({name, "_rsp_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_bus_left"}, 32'(bus_q.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        bus_q.delete();
    endtask

    // Response and bus-start monitors: every pop and every start is matched in order.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=%0h required=none", {rsp_rdata, rsp_write, rsp_err});
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_order", 32'({rsp_rdata, rsp_write, rsp_err}), 32'(mon_e));
            end
        end
        if (!reset && pb_start) begin
            check("start_width", 32'(prev_start), 32'd0);
            if (bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_unexpected actual=%0h required=none", bus_fields);
            end else begin
                mon_b = bus_q.pop_front();
                check("bus_fields", 32'(bus_fields), 32'(mon_b));
            end
        end
        prev_start = pb_start;
    end

    // Slave: answers each start after 0..3 extra WAIT cycles, checking the fields hold.
    initial begin
        pb_ready = 1'b0;
        pb_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (slave_auto && pb_start && !reset) begin
                sl_f = bus_fields;
                sl_d = slave_rand ? int'($urandom_range(0, 3)) : 0;
                for (int i = 0; i <= sl_d; i++) begin
                    step();
                    check("pb_hold", 32'(bus_fields), 32'(sl_f));
                end
                pb_rdata = pb_write ? 8'($urandom) : slave_data(pb_addr);
                pb_ready = 1'b1;
                step();
                pb_ready = 1'b0;
                pb_rdata = 8'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_rand = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int lat;
        int cnt;

        tbl[0] = '{1'b1, 2'd1, 8'h10, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 2'd2, 8'h20, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 8'h44, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 2'd0, 8'h45, 8'h99, 8'h03, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 2'd3, 8'hFF, 8'h00, 8'h05, 8'hE3, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 2'd1, 8'h00, 8'h00, 8'h00, 8'h1C, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 2'd3, 8'h80, 8'h5A, 8'h07, 8'h00, 1'b1, 1'b0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_sel   = 2'd0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        cmd_wait  = 8'h00;
        repeat (3) step();
        reset = 1'b0;

        check("rst_pb_start", 32'(pb_start), 32'd0);
        check("rst_pb_fields", 32'(bus_fields), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single write: start pulse timing, field hold, response timing.
        slave_auto = 1'b1;
        send_cmd(1'b1, 2'd1, 8'h10, 8'hA5, 8'h00);
        check("w1_start_n1", 32'(pb_start), 32'd0);
        step();
        check("w1_start_n2", 32'(pb_start), 32'd1);
        check("w1_fields", 32'(bus_fields), 32'({1'b1, 2'd1, 8'h10, 8'hA5, 8'h00}));
        step();
        check("w1_start_off", 32'(pb_start), 32'd0);
        check("w1_addr_held", 32'(pb_addr), 32'h10);
        step();
        check("w1_rsp_early", 32'(rsp_valid), 32'd0);
        step();
        check("w1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("w1_rsp", 32'({rsp_rdata, rsp_write, rsp_err}), 32'({8'h00, 1'b1, 1'b0}));
        check("w1_sel_clear", 32'(pb_sel), 32'd0);
        check("w1_busy", 32'(busy), 32'd0);
        rsp_man = 1'b1;
        step();
        rsp_man = 1'b0;

        // Vector table: one command at a time, zero-delay slave.
        for (int i = 0; i < 7; i++) begin
            send_cmd(tbl[i].w, tbl[i].sel, tbl[i].addr, tbl[i].wdata, tbl[i].wt);
            lat = 0;
            while (!rsp_valid && lat < 50) begin
                step();
                lat++;
            end
            check($sformatf("tbl%0d_lat", i), 32'(lat), (tbl[i].sel == 2'd0) ? 32'd2 : 32'd4);
            check($sformatf("tbl%0d_rdata", i), 32'(rsp_rdata), 32'(tbl[i].rdata));
            check($sformatf("tbl%0d_write", i), 32'(rsp_write), 32'(tbl[i].rw));
            check($sformatf("tbl%0d_err", i), 32'(rsp_err), 32'(tbl[i].err));
            rsp_man = 1'b1;
            step();
            rsp_man = 1'b0;
            step();
        end

        // Back-pressure: four responses pending plus a full command queue.
        for (int i = 0; i < 8; i++) begin
            send_cmd(1'b0, 2'(1 + i % 3), 8'(8'h40 + i), 8'h00, 8'h00);
        end
        repeat (10) step();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pb_start) cnt++;
        end
        check("full_no_start", 32'(cnt), 32'd0);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_rsp_valid", 32'(rsp_valid), 32'd1);
        check("full_busy", 32'(busy), 32'd1);
        check("full_pending", 32'(exp_q.size()), 32'd8);
        drain("full");

        // Reset while waiting on the bus with two commands still queued.
        slave_auto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_cmd(1'b0, 2'd1, 8'(8'h60 + i), 8'h00, 8'h00);
        end
        cnt = 0;
        while (fsm_state != 2'd2 && cnt < 20) begin
            step();
            cnt++;
        end
        check("rstw_in_wait", 32'(fsm_state), 32'd2);
        pulse_reset();
        check("rstw_pb_start", 32'(pb_start), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid || pb_start) cnt++;
        end
        check("rstw_quiet", 32'(cnt), 32'd0);

        // Slave never answers.
        send_cmd(1'b0, 2'd2, 8'h77, 8'h00, 8'h00);
        cnt = 0;
        while (fsm_state != 2'd2 && cnt < 20) begin
            step();
            cnt++;
        end
        cnt = 0;
        while (fsm_state == 2'd2 && cnt < 200) begin
            step();
            cnt++;
        end
`ifdef PBR_TIMEOUT_EN
        void'(exp_q.pop_back());
        exp_q.push_back({8'h00, 1'b0, 1'b1});
        check("to_wait_cycles", 32'(cnt), 32'd64);
        step();
        check("to_rsp", 32'({rsp_valid, rsp_rdata, rsp_write, rsp_err}), 32'({1'b1, 8'h00, 1'b0, 1'b1}));
        drain("to");
`else
        check("to_wait_hold", 32'(cnt), 32'd200);
        check("to_no_rsp", 32'(rsp_valid), 32'd0);
        pulse_reset();
`endif

        // Randomized traffic against the in-order model.
        slave_auto = 1'b1;
        slave_rand = 1'b1;
        rand_rsp   = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                     8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end
        rand_rsp = 1'b0;
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
